// File: rtl/wb_pkg.sv
// Shared widths, register-index constants and the write-request record for the writeback path.
package wb_pkg;
    localparam int DATA_W    = 8;
    localparam int REG_AW    = 3;
    localparam int NUM_GPR   = 7;
    localparam int COND_REG  = 5;
    localparam int NUM_LABEL = COND_REG + 1;
    localparam int ZERO_IDX  = 7;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              cond;
        logic              is_label;
    } wb_req_t;

    function automatic logic is_gpr(input logic [REG_AW-1:0] idx);
        return int'(idx) != ZERO_IDX;
    endfunction

    function automatic logic is_label_idx(input logic [REG_AW-1:0] idx);
        return int'(idx) < NUM_LABEL;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// Latency: pushed data readable at dout_o the cycle after the push; pushes while full / pops while empty are ignored.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU results and buffered load results into one registered register-file write per cycle.
// Latency: a result selected in cycle N is on the write port in cycle N+1 for one cycle.
// Backpressure: mem_ready = FIFO not full; stall_o holds the ALU off once a load has waited MAX_WAIT cycles.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_valid,
    input  logic [REG_AW-1:0]  alu_rd,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic               alu_cond,
    input  logic               alu_label,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [REG_AW-1:0]  mem_rd,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               ld_issue,
    input  logic [REG_AW-1:0]  ld_issue_rd,
    output logic [REG_AW-1:0]  rd,
    output logic [DATA_W-1:0]  write_data,
    output logic               condition_bit,
    output logic               reg_write,
    output logic               label_write,
    output logic [NUM_GPR-1:0] pending,
    output logic               stall_o,
    output logic               err_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    wb_req_t            mem_req, head;
    wb_req_t            out_q, out_d;
    logic               fifo_full, fifo_empty, push, pop;
    logic               wr_q, wr_d;
    logic               cond_shadow_q, cond_shadow_d;
    logic               err_q, err_d;
    logic               stall_q, stall_d;
    logic [NUM_GPR-1:0] pending_q, pending_d;
    logic [CW-1:0]      wait_q, wait_d;

    assign mem_ready = !fifo_full;
    assign push      = mem_valid && !fifo_full;
    assign pop       = !alu_valid && !fifo_empty;
    assign mem_req   = '{rd: mem_rd, data: mem_data, cond: 1'b0, is_label: 1'b0};

    wb_fifo #(.W($bits(wb_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (mem_req),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        out_d         = out_q;
        wr_d          = 1'b0;
        cond_shadow_d = cond_shadow_q;
        err_d         = err_q;
        pending_d     = pending_q;
        wait_d        = wait_q;
        stall_d       = stall_q;

        if (alu_valid) begin
            if (stall_q) err_d = 1'b1;
            if (alu_label) begin
                if (is_label_idx(alu_rd)) begin
                    wr_d  = 1'b1;
                    out_d = '{rd: alu_rd, data: alu_data, cond: out_q.cond, is_label: 1'b1};
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_gpr(alu_rd)) begin
                wr_d          = 1'b1;
                out_d         = '{rd: alu_rd, data: alu_data, cond: alu_cond, is_label: 1'b0};
                cond_shadow_d = alu_cond;
            end else begin
                err_d = 1'b1;
            end
        end else if (pop) begin
            if (is_gpr(head.rd)) begin
                wr_d                = 1'b1;
                out_d               = head;
                // Loads rewrite r5 too, so carry the last ALU condition through.
                out_d.cond          = cond_shadow_q;
                out_d.is_label      = 1'b0;
                pending_d[head.rd]  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (ld_issue && is_gpr(ld_issue_rd)) pending_d[ld_issue_rd] = 1'b1;

        if (fifo_empty || pop)     wait_d = '0;
        else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;

        if (fifo_empty)                stall_d = 1'b0;
        else if (wait_d == WAIT_MAX)   stall_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q         <= '0;
            wr_q          <= 1'b0;
            cond_shadow_q <= 1'b0;
            err_q         <= 1'b0;
            stall_q       <= 1'b0;
            pending_q     <= '0;
            wait_q        <= '0;
        end else begin
            out_q         <= out_d;
            wr_q          <= wr_d;
            cond_shadow_q <= cond_shadow_d;
            err_q         <= err_d;
            stall_q       <= stall_d;
            pending_q     <= pending_d;
            wait_q        <= wait_d;
        end
    end

    assign rd            = out_q.rd;
    assign write_data    = out_q.data;
    assign condition_bit = out_q.cond;
    assign reg_write     = wr_q && !out_q.is_label;
    assign label_write   = wr_q && out_q.is_label;
    assign pending       = pending_q;
    assign stall_o       = stall_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboarded bench for writeback_unit: ALU and load expectations queued at drive time, popped on each write strobe.
module tb_writeback_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_valid = 1'b0;
    logic [2:0] alu_rd = '0;
    logic [7:0] alu_data = '0;
    logic       alu_cond = 1'b0;
    logic       alu_label = 1'b0;
    logic       mem_valid = 1'b0;
    logic       mem_ready;
    logic [2:0] mem_rd = '0;
    logic [7:0] mem_data = '0;
    logic       ld_issue = 1'b0;
    logic [2:0] ld_issue_rd = '0;
    logic [2:0] rd;
    logic [7:0] write_data;
    logic       condition_bit, reg_write, label_write;
    logic [6:0] pending;
    logic       stall_o, err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
        logic       cond;
        logic       is_label;
    } exp_t;

    exp_t exp_alu[$];
    exp_t exp_mem[$];
    logic src_alu = 1'b0;
    logic model_cond = 1'b0;
    logic model_cbit = 1'b0;

    writeback_unit #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_cond(alu_cond), .alu_label(alu_label),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .rd(rd), .write_data(write_data), .condition_bit(condition_bit),
        .reg_write(reg_write), .label_write(label_write),
        .pending(pending), .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            src_alu = alu_valid;
            if (!rst_n) model_cond = 1'b0;
            else if (alu_valid && !alu_label && alu_rd != 3'd7) model_cond = alu_cond;
            @(negedge clk);
            if (!rst_n) model_cbit = 1'b0;
            if (reg_write || label_write) begin
                checks++;
                if ((src_alu && exp_alu.size() == 0) || (!src_alu && exp_mem.size() == 0)) begin
                    errors++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h rw=%b lw=%b, required no write", rd, write_data, reg_write, label_write);
                end else begin
                    if (src_alu) e = exp_alu.pop_front();
                    else begin
                        e = exp_mem.pop_front();
                        e.cond = model_cond;
                    end
                    if (e.is_label) e.cond = model_cbit;
                    else model_cbit = e.cond;
                    if ({rd, write_data, condition_bit, reg_write, label_write} !==
                        {e.rd, e.data, e.cond, !e.is_label, e.is_label}) begin
                        errors++;
                        $display("FAIL write_port: got rd=%0d data=%h cond=%b rw=%b lw=%b, required rd=%0d data=%h cond=%b rw=%b lw=%b",
                                 rd, write_data, condition_bit, reg_write, label_write,
                                 e.rd, e.data, e.cond, !e.is_label, e.is_label);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic label, input logic [2:0] r, input logic [7:0] d, input logic c);
        exp_t e;
        alu_valid = v; alu_label = label; alu_rd = r; alu_data = d; alu_cond = c;
        if (v && (label ? (r <= 3'd5) : (r <= 3'd6))) begin
            e = '{r, d, c, label};
            exp_alu.push_back(e);
        end
    endtask

    task automatic drive_mem(input logic v, input logic [2:0] r, input logic [7:0] d);
        exp_t e;
        mem_valid = v; mem_rd = r; mem_data = d;
        if (v) begin
            e = '{r, d, 1'b0, 1'b0};
            exp_mem.push_back(e);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rd, write_data, condition_bit, reg_write, label_write} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h, required 0", {rd, write_data, condition_bit, reg_write, label_write});
        end
        checks++;
        if ({pending, stall_o, err_o} !== '0) begin
            errors++; $display("FAIL reset_state: got %h, required 0", {pending, stall_o, err_o});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mem_ready: got %b, required 1", mem_ready);
        end
        checks++;
        if ({reg_write, label_write, pending, stall_o, err_o} !== '0) begin
            errors++; $display("FAIL post_reset_idle: got %h, required 0", {reg_write, label_write, pending, stall_o, err_o});
        end
    endtask

    task automatic test_alu_write();
        drive_alu(1'b1, 1'b0, 3'd2, 8'h3C, 1'b1);
        tick();
        drive_alu(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        checks++;
        if ({rd, write_data, condition_bit, reg_write} !== {3'd2, 8'h3C, 1'b1, 1'b1}) begin
            errors++; $display("FAIL alu_write: got rd=%0d data=%h cond=%b rw=%b, required rd=2 data=3c cond=1 rw=1", rd, write_data, condition_bit, reg_write);
        end
        tick();
        checks++;
        if (reg_write !== 1'b0) begin
            errors++; $display("FAIL alu_one_cycle: got rw=%b, required 0", reg_write);
        end
    endtask

    task automatic test_load();
        ld_issue = 1'b1; ld_issue_rd = 3'd3;
        tick();
        ld_issue = 1'b0;
        checks++;
        if (pending !== 7'b0001000) begin
            errors++; $display("FAIL load_pending_set: got %b, required 0001000", pending);
        end
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready: got %b, required 1", mem_ready);
        end
        drive_mem(1'b1, 3'd3, 8'hA5);
        tick();
        drive_mem(1'b0, 3'd0, 8'h00);
        checks++;
        if ({pending[3], reg_write} !== 2'b10) begin
            errors++; $display("FAIL load_in_flight: got pending3=%b rw=%b, required 1 0", pending[3], reg_write);
        end
        tick();
        checks++;
        if ({reg_write, rd, write_data, condition_bit, pending} !== {1'b1, 3'd3, 8'hA5, 1'b1, 7'b0}) begin
            errors++; $display("FAIL load_write: got rw=%b rd=%0d data=%h cond=%b pend=%b, required 1 3 a5 1 0000000",
                               reg_write, rd, write_data, condition_bit, pending);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        drive_alu(1'b1, 1'b0, 3'd1, 8'h40, 1'b0);
        drive_mem(1'b1, 3'd4, 8'h81);
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_empty: got %b, required 1", mem_ready);
        end
        tick();
        drive_alu(1'b1, 1'b0, 3'd1, 8'h41, 1'b0);
        drive_mem(1'b1, 3'd6, 8'h82);
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_one: got %b, required 1", mem_ready);
        end
        tick();
        drive_mem(1'b0, 3'd0, 8'h00);
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_full: got %b, required 0", mem_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, 1'b0, 3'd1, 8'(8'h42 + i), 1'b0);
            tick();
            checks++;
            if (stall_o !== (i == 2)) begin
                errors++; $display("FAIL b2b_stall_rise[%0d]: got %b, required %b", i, stall_o, (i == 2));
            end
        end
        drive_alu(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        n = 0;
        while (stall_o === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL b2b_stall_fall: got %0d cycles, required 3", n);
        end
        checks++;
        if ({exp_mem.size() == 0, mem_ready, err_o} !== 3'b110) begin
            errors++; $display("FAIL b2b_drain: got drained=%b ready=%b err=%b, required 1 1 0", exp_mem.size() == 0, mem_ready, err_o);
        end
    endtask

    task automatic test_label();
        drive_alu(1'b1, 1'b1, 3'd5, 8'h11, 1'b1);
        tick();
        drive_alu(1'b1, 1'b1, 3'd6, 8'h22, 1'b1);
        checks++;
        if ({label_write, reg_write, err_o} !== 3'b100) begin
            errors++; $display("FAIL label_write: got lw=%b rw=%b err=%b, required 1 0 0", label_write, reg_write, err_o);
        end
        tick();
        drive_alu(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        checks++;
        if ({label_write, reg_write, err_o} !== 3'b001) begin
            errors++; $display("FAIL label_illegal: got lw=%b rw=%b err=%b, required 0 0 1", label_write, reg_write, err_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b, required 1", err_o);
        end
    endtask

    task automatic test_same_cycle();
        ld_issue = 1'b1; ld_issue_rd = 3'd4;
        tick();
        ld_issue_rd = 3'd7;
        drive_mem(1'b1, 3'd4, 8'h5A);
        tick();
        drive_mem(1'b0, 3'd0, 8'h00);
        ld_issue_rd = 3'd4;
        checks++;
        if (pending !== 7'b0010000) begin
            errors++; $display("FAIL pending_rd7_ignored: got %b, required 0010000", pending);
        end
        tick();
        ld_issue = 1'b0;
        checks++;
        if ({reg_write, rd, pending} !== {1'b1, 3'd4, 7'b0010000}) begin
            errors++; $display("FAIL set_wins: got rw=%b rd=%0d pend=%b, required 1 4 0010000", reg_write, rd, pending);
        end
        drive_mem(1'b1, 3'd4, 8'h5B);
        tick();
        drive_mem(1'b0, 3'd0, 8'h00);
        tick();
        checks++;
        if (pending !== 7'b0) begin
            errors++; $display("FAIL pending_clear: got %b, required 0000000", pending);
        end
    endtask

    task automatic test_reset_mid();
        ld_issue = 1'b1; ld_issue_rd = 3'd1;
        drive_alu(1'b1, 1'b0, 3'd0, 8'h60, 1'b1);
        drive_mem(1'b1, 3'd1, 8'h91);
        tick();
        ld_issue = 1'b0;
        drive_alu(1'b1, 1'b0, 3'd0, 8'h61, 1'b1);
        drive_mem(1'b1, 3'd2, 8'h92);
        tick();
        drive_alu(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        drive_mem(1'b0, 3'd0, 8'h00);
        checks++;
        if ({mem_ready, pending} !== {1'b0, 7'b0000010}) begin
            errors++; $display("FAIL mid_buffered: got ready=%b pend=%b, required 0 0000010", mem_ready, pending);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_mem.delete();
        #1;
        checks++;
        if ({rd, write_data, condition_bit, reg_write, label_write, pending, stall_o, err_o} !== '0) begin
            errors++; $display("FAIL mid_reset_clear: got %h, required 0",
                               {rd, write_data, condition_bit, reg_write, label_write, pending, stall_o, err_o});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ready: got %b, required 1", mem_ready);
        end
        repeat (5) tick();
        checks++;
        if ({reg_write, label_write, pending, err_o} !== '0) begin
            errors++; $display("FAIL mid_reset_stale: got %h, required 0", {reg_write, label_write, pending, err_o});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_write();
        test_load();
        test_back_to_back();
        test_label();
        test_same_cycle();
        test_reset_mid();
        checks++;
        if (exp_alu.size() + exp_mem.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: got %0d outstanding, required 0", exp_alu.size() + exp_mem.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the register-file write port. Merges ALU results (no backpressure) and multi-cycle memory-load results (valid/ready) into one registered write per cycle.
- Drives rd, write_data, condition_bit, reg_write and label_write into the register file.
- Keeps a pending-load scoreboard so decode can detect hazards against loads that are still in flight.

Parameters:
DATA_W, 8, data width of results and register-file write data
REG_AW, 3, register index width
FIFO_DEPTH, 2, memory-result buffer entries (power of 2, >=2)
MAX_WAIT, 4, cycles the FIFO head may wait before stall_o asserts

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present this cycle; must be 0 while stall_o=1
alu_rd  in  REG_AW  destination index
alu_data  in  DATA_W  result value
alu_cond  in  1  condition bit produced by this instruction
alu_label  in  1  1 = write label register alu_rd, 0 = general register
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted (FIFO not full)
mem_rd  in  REG_AW  load destination (general only)
mem_data  in  DATA_W  load value
ld_issue  in  1  load issued this cycle (sets scoreboard)
ld_issue_rd  in  REG_AW  issued load destination
rd  out  REG_AW  register-file write index
write_data  out  DATA_W  register-file write value
condition_bit  out  1  value written to r5 alongside every general write
reg_write  out  1  general write strobe
label_write  out  1  label write strobe
pending  out  7  bit i = load to general reg i outstanding
stall_o  out  1  upstream must hold alu_valid low
err_o  out  1  sticky: illegal index dropped

Behaviour:
- Reset (async, rst_n=0) clears every output and all state:
  - rd=0, write_data=0, condition_bit=0, reg_write=0, label_write=0.
  - pending=0, stall_o=0, err_o=0.
  - FIFO empty, so mem_ready=1 once out of reset.
  - cond_shadow=0, wait counter=0.
  - Reset mid-operation discards buffered loads and pending bits.
- Output latency: all register-file outputs are registered. A result selected in cycle N appears on the outputs in cycle N+1 for exactly one cycle. The register file samples on the following negedge.
- mem_ready is combinational: mem_ready = !full. A load transfers when mem_valid && mem_ready and is pushed into the FIFO.
- Selection each cycle:
  - alu_valid=1: issue the ALU result. The FIFO holds.
  - Otherwise, if the FIFO is non-empty: pop the head and issue it.
  - Push and pop in the same cycle are allowed; a push into a full FIFO is impossible because mem_ready=0.
- ALU general write (alu_label=0):
  - alu_rd<=6: reg_write=1, condition_bit=alu_cond, and cond_shadow<=alu_cond.
  - alu_rd=7: dropped, err_o<=1, no strobe.
- ALU label write (alu_label=1):
  - alu_rd<=5: label_write=1, reg_write=0. condition_bit and cond_shadow are unchanged.
  - alu_rd>5: dropped, err_o<=1.
- Memory write: reg_write=1, condition_bit=cond_shadow, so the register file's r5 overwrite preserves the last ALU condition. mem_rd=7 is dropped with err_o<=1.
- Scoreboard:
  - ld_issue with ld_issue_rd<=6 sets pending[ld_issue_rd].
  - Issuing a memory write clears pending[mem_rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - ld_issue_rd=7 is ignored.
- Starvation control:
  - wait counter increments each cycle the FIFO is non-empty and not popped; it resets to 0 on a pop or when the FIFO is empty.
  - When the counter reaches MAX_WAIT, stall_o<=1 (registered).
  - stall_o stays 1 until the FIFO is empty, then deasserts the next cycle.
  - If alu_valid=1 while stall_o=1 (protocol violation): set err_o and still give the ALU priority.
- FIFO pointers use one extra wrap bit. full = index bits equal with wrap bits differing; empty = pointers equal.

Decomposition:
- Shared package wb_pkg holds:
  - DATA_W and REG_AW.
  - Constants: NUM_GPR=7, NUM_LABEL=6, COND_REG=5, ZERO_IDX=7.
  - Typedef wb_req_t {rd, data, cond, is_label}, used for the output register and FIFO entries.
- One sub-module, wb_fifo: a parameterised synchronous FIFO with push/pop/full/empty and asynchronous active-low reset. Selection, scoreboard and starvation logic stay in the top level.

Test Plan:
- ALU writes alu_rd=2, data 0x3C, cond=1 → next cycle rd=2, write_data=0x3C, reg_write=1, condition_bit=1; one cycle only.
- ld_issue rd=3; load 0xA5 to rd=3 with ALU idle → pending[3]=1, then write rd=3, data 0xA5, condition_bit=cond_shadow (last ALU cond, 1); pending[3] clears the same cycle as the strobe.
- Two loads back-to-back with the ALU busy every cycle → mem_ready drops after 2 pushes; stall_o rises after MAX_WAIT=4 waiting cycles; with alu_valid then 0, loads write in order and stall_o falls once the FIFO is empty.
- ALU label write rd=5 data 0x11, then rd=6 → first gives label_write=1, reg_write=0; second gives no strobe and err_o=1 (sticky).
- Same-cycle memory write to r4 and ld_issue rd=4 → pending[4] stays 1.
- Assert rst_n=0 with 2 buffered loads → all outputs 0 immediately; after release mem_ready=1 and no stale write appears.
